// File: rtl/cpu32_pkg.sv
// Shared constants for cpu32 and its program loader: widths, halt opcode
// and the loader state encoding.
package cpu32_pkg;

    localparam int ADDR_W = 8;
    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    // Returned for any fetch outside the loaded image; halts cpu32.
    localparam logic [15:0] HALT_CODE = 16'hF000;

    // Loader state encoding
    localparam logic [2:0] LOAD_HI = 3'd0;
    localparam logic [2:0] LOAD_LO = 3'd1;
    localparam logic [2:0] LOAD_CK = 3'd2;
    localparam logic [2:0] RUN     = 3'd3;
    localparam logic [2:0] ERR     = 3'd4;

endpackage

// File: rtl/program_ram.sv
// Instruction store for cpu32: synchronous write, asynchronous read, no reset.
module program_ram
    import cpu32_pkg::*;
#(
    parameter int AW    = cpu32_pkg::ADDR_W,
    parameter int DW    = cpu32_pkg::WORD_W,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port: one word per enabled edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// Byte-serial program image loader and instruction store for cpu32.
// Packs a valid/ready byte stream (hi byte first) into 16-bit words, serves
// code[pc] combinationally and releases the CPU via cpu_power once loaded.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing 8-bit checksum byte).
module program_loader
    import cpu32_pkg::*;
#(
    parameter int ADDR_W    = cpu32_pkg::ADDR_W,
    parameter int WORD_W    = cpu32_pkg::WORD_W,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              power,
    input  logic [7:0]        ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_last,
    input  logic [ADDR_W-1:0] pc,
    output logic [WORD_W-1:0] code,
    output logic              cpu_power,
    output logic [ADDR_W:0]   words_loaded,
    output logic              load_err
);

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] END_STATE = LOAD_CK;
`else
    localparam logic [2:0] END_STATE = RUN;
`endif

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [7:0]        hi_q;
    logic [ADDR_W:0]   words_q;
    logic              accept;
    logic              word_we;
    logic [WORD_W-1:0] ram_rdata;

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] sum_q;
    logic [BYTE_W-1:0] ck_total;
    assign ck_total = sum_q + ld_data;
`endif

    // Ready, run and error flags come straight from the state register
`ifdef LOADER_CHECKSUM_EN
    assign ld_ready = (state_q == LOAD_HI) || (state_q == LOAD_LO) || (state_q == LOAD_CK);
`else
    assign ld_ready = (state_q == LOAD_HI) || (state_q == LOAD_LO);
`endif
    assign cpu_power    = (state_q == RUN);
    assign load_err     = (state_q == ERR);
    assign words_loaded = words_q;

    assign accept  = ld_valid && ld_ready;
    assign word_we = accept && (state_q == LOAD_LO) && (words_q < MAX_CNT);

    // Next-state logic for the load sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_HI: begin
                if (accept) begin
                    state_d = ld_last ? ERR : LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (accept) begin
                    if (ld_last || (words_q == MAX_CNT - 1'b1)) begin
                        state_d = END_STATE;
                    end else begin
                        state_d = LOAD_HI;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            LOAD_CK: begin
                if (accept) begin
                    state_d = (ck_total == '0) ? RUN : ERR;
                end
            end
`endif
            default: state_d = state_q;
        endcase
    end

    // State, hi-byte latch and saturating word counter
    always_ff @(posedge clk or negedge power) begin
        if (!power) begin
            state_q <= LOAD_HI;
            hi_q    <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept && (state_q == LOAD_HI)) begin
                hi_q <= ld_data;
            end
            if (word_we) begin
                words_q <= words_q + 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running sum over every accepted image byte (checksum byte excluded)
    always_ff @(posedge clk or negedge power) begin
        if (!power) begin
            sum_q <= '0;
        end else if (accept && ((state_q == LOAD_HI) || (state_q == LOAD_LO))) begin
            sum_q <= sum_q + ld_data;
        end
    end
`endif

    program_ram #(
        .AW    (ADDR_W),
        .DW    (WORD_W),
        .DEPTH (MAX_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (word_we),
        .waddr (words_q[ADDR_W-1:0]),
        .wdata ({hi_q, ld_data}),
        .raddr (pc),
        .rdata (ram_rdata)
    );

    // Stale RAM contents beyond the loaded count read back as a halt
    assign code = ({1'b0, pc} < words_q) ? ram_rdata : WORD_W'(HALT_CODE);

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
// Checksum scenario is compiled in when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

    logic        clk;
    logic        power;
    logic [7:0]  ld_data;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_last;
    logic [7:0]  pc;
    logic [15:0] code;
    logic        cpu_power;
    logic [8:0]  words_loaded;
    logic        load_err;

    int tests_run;
    int tests_failed;

    program_loader #(
        .ADDR_W    (8),
        .WORD_W    (16),
        .MAX_WORDS (256)
    ) dut (
        .clk          (clk),
        .power        (power),
        .ld_data      (ld_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_last      (ld_last),
        .pc           (pc),
        .code         (code),
        .cpu_power    (cpu_power),
        .words_loaded (words_loaded),
        .load_err     (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reset_dut();
        @(negedge clk);
        power    = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = 8'h00;
        pc       = 8'h00;
        @(negedge clk);
        @(negedge clk);
        power = 1'b1;
    endtask

    // One byte presented for exactly one rising edge
    task automatic send_byte(input logic [7:0] d, input logic last);
        @(negedge clk);
        ld_data  = d;
        ld_valid = 1'b1;
        ld_last  = last;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        power    = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
        tests_run++;
        if (ld_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ld_ready: got %b expected 1", ld_ready); end
        tests_run++;
        if (cpu_power !== 1'b0) begin tests_failed++; $display("FAIL reset_cpu_power: got %b expected 0", cpu_power); end
        tests_run++;
        if (words_loaded !== 9'd0) begin tests_failed++; $display("FAIL reset_words: got %0d expected 0", words_loaded); end
        tests_run++;
        if (load_err !== 1'b0) begin tests_failed++; $display("FAIL reset_load_err: got %b expected 0", load_err); end
        @(negedge clk);
        power = 1'b1;
    endtask

    task automatic test_basic_load();
        reset_dut();
        send_byte(8'h00, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'h00, 1'b0);
        tests_run++;
        if (cpu_power !== 1'b0) begin tests_failed++; $display("FAIL load_early_power: got %b expected 0", cpu_power); end
        send_byte(8'h12, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h94, 1'b0);
`endif
        tests_run++;
        if (cpu_power !== 1'b1) begin tests_failed++; $display("FAIL load_cpu_power: got %b expected 1", cpu_power); end
        tests_run++;
        if (words_loaded !== 9'd2) begin tests_failed++; $display("FAIL load_words: got %0d expected 2", words_loaded); end
        tests_run++;
        if (ld_ready !== 1'b0) begin tests_failed++; $display("FAIL load_ready: got %b expected 0", ld_ready); end
    endtask

    task automatic test_fetch();
        pc = 8'd0;
        #1;
        tests_run++;
        if (code !== 16'h005A) begin tests_failed++; $display("FAIL fetch_pc0: got %h expected 005a", code); end
        pc = 8'd1;
        #1;
        tests_run++;
        if (code !== 16'h0012) begin tests_failed++; $display("FAIL fetch_pc1: got %h expected 0012", code); end
        pc = 8'd2;
        #1;
        tests_run++;
        if (code !== 16'hF000) begin tests_failed++; $display("FAIL fetch_pc2: got %h expected f000", code); end
    endtask

    task automatic test_odd_error();
        reset_dut();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        tests_run++;
        if (load_err !== 1'b1) begin tests_failed++; $display("FAIL odd_load_err: got %b expected 1", load_err); end
        tests_run++;
        if (cpu_power !== 1'b0) begin tests_failed++; $display("FAIL odd_cpu_power: got %b expected 0", cpu_power); end
        tests_run++;
        if (ld_ready !== 1'b0) begin tests_failed++; $display("FAIL odd_ready: got %b expected 0", ld_ready); end
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h11, 1'b0);
        end
        tests_run++;
        if (words_loaded !== 9'd1) begin tests_failed++; $display("FAIL odd_words: got %0d expected 1", words_loaded); end
        tests_run++;
        if (load_err !== 1'b1) begin tests_failed++; $display("FAIL odd_err_held: got %b expected 1", load_err); end
        pc = 8'd0;
        #1;
        tests_run++;
        if (code !== 16'hAABB) begin tests_failed++; $display("FAIL odd_code0: got %h expected aabb", code); end
    endtask

    // Back-to-back bytes with ld_valid held high; byte i carries value i mod 256
    task automatic test_full_image();
        reset_dut();
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (i == 511) begin
                tests_run++;
                if (cpu_power !== 1'b0) begin tests_failed++; $display("FAIL full_early_power: got %b expected 0", cpu_power); end
                tests_run++;
                if (words_loaded !== 9'd255) begin tests_failed++; $display("FAIL full_words_pre: got %0d expected 255", words_loaded); end
            end
            ld_data  = 8'(i);
            ld_valid = 1'b1;
            ld_last  = 1'b0;
        end
        @(negedge clk);
        ld_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b0);
`endif
        tests_run++;
        if (cpu_power !== 1'b1) begin tests_failed++; $display("FAIL full_cpu_power: got %b expected 1", cpu_power); end
        tests_run++;
        if (words_loaded !== 9'd256) begin tests_failed++; $display("FAIL full_words: got %0d expected 256", words_loaded); end
        tests_run++;
        if (ld_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready: got %b expected 0", ld_ready); end
        send_byte(8'h77, 1'b1);
        tests_run++;
        if (words_loaded !== 9'd256) begin tests_failed++; $display("FAIL full_saturate: got %0d expected 256", words_loaded); end
        pc = 8'd0;
        #1;
        tests_run++;
        if (code !== 16'h0001) begin tests_failed++; $display("FAIL full_code0: got %h expected 0001", code); end
        pc = 8'd255;
        #1;
        tests_run++;
        if (code !== 16'hFEFF) begin tests_failed++; $display("FAIL full_code255: got %h expected feff", code); end
    endtask

    task automatic test_gaps_and_reset();
        reset_dut();
        @(negedge clk); ld_data = 8'h12; ld_valid = 1'b0;
        @(negedge clk); ld_data = 8'h12; ld_valid = 1'b1;
        @(negedge clk); ld_data = 8'h99; ld_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (words_loaded !== 9'd0) begin tests_failed++; $display("FAIL gap_words_mid: got %0d expected 0", words_loaded); end
        @(negedge clk); ld_data = 8'h34; ld_valid = 1'b1;
        @(negedge clk); ld_data = 8'h99; ld_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (words_loaded !== 9'd1) begin tests_failed++; $display("FAIL gap_words: got %0d expected 1", words_loaded); end
        pc = 8'd0;
        #1;
        tests_run++;
        if (code !== 16'h1234) begin tests_failed++; $display("FAIL gap_code0: got %h expected 1234", code); end
        send_byte(8'h56, 1'b0);
        @(negedge clk);
        power = 1'b0;
        #1;
        tests_run++;
        if (words_loaded !== 9'd0) begin tests_failed++; $display("FAIL midreset_words: got %0d expected 0", words_loaded); end
        tests_run++;
        if (ld_ready !== 1'b1) begin tests_failed++; $display("FAIL midreset_ready: got %b expected 1", ld_ready); end
        for (int p = 0; p < 256; p++) begin
            pc = 8'(p);
            #1;
            tests_run++;
            if (code !== 16'hF000) begin tests_failed++; $display("FAIL midreset_code pc=%0d: got %h expected f000", p, code); end
        end
        @(negedge clk);
        power = 1'b1;
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        reset_dut();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        tests_run++;
        if (ld_ready !== 1'b1) begin tests_failed++; $display("FAIL ck_wait_ready: got %b expected 1", ld_ready); end
        tests_run++;
        if (cpu_power !== 1'b0) begin tests_failed++; $display("FAIL ck_wait_power: got %b expected 0", cpu_power); end
        send_byte(8'hFD, 1'b1);
        tests_run++;
        if (cpu_power !== 1'b1) begin tests_failed++; $display("FAIL ck_good_power: got %b expected 1", cpu_power); end
        reset_dut();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        send_byte(8'hFC, 1'b0);
        tests_run++;
        if (load_err !== 1'b1) begin tests_failed++; $display("FAIL ck_bad_err: got %b expected 1", load_err); end
        tests_run++;
        if (cpu_power !== 1'b0) begin tests_failed++; $display("FAIL ck_bad_power: got %b expected 0", cpu_power); end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        power        = 1'b0;
        ld_data      = 8'h00;
        ld_valid     = 1'b0;
        ld_last      = 1'b0;
        pc           = 8'h00;
        test_reset();
        test_basic_load();
        test_fetch();
        test_odd_error();
        test_full_image();
        test_gaps_and_reset();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
